// File: rtl/spi_master_txq_pkg.sv
// spi_master_txq shared definitions.
// Register map constant, datamode encodings and FSM state type.
package spi_master_txq_pkg;

    localparam logic [5:0] SPI_TX        = 6'h08;
    localparam int         SPI_TXQ_DEPTH = 16;

    localparam logic [1:0] DM_BYTE   = 2'd0;
    localparam logic [1:0] DM_HALF   = 2'd1;
    localparam logic [1:0] DM_WORD   = 2'd2;
    localparam logic [1:0] DM_DOUBLE = 2'd3;

    typedef enum logic {
        TXQ_IDLE,
        TXQ_SHIFT
    } txq_state_t;

    function automatic logic [3:0] dm_nbytes(input logic [1:0] dm);
        return 4'd1 << dm;
    endfunction

endpackage

// File: rtl/spi_txq_mem.sv
// Synchronous circular FIFO, first-word-fall-through.
// Tracks occupancy, full/empty, programmable almost-full, sticky underflow.
module spi_txq_mem #(
    parameter int SW    = 8,
    parameter int DEPTH = 16,
    parameter int FAW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           clear,
    input  logic           wr_en,
    input  logic [SW-1:0]  din,
    input  logic           rd_en,
    input  logic [FAW:0]   prog_thresh,
    output logic [SW-1:0]  dout,
    output logic           empty,
    output logic           full,
    output logic           prog_full,
    output logic [FAW:0]   count,
    output logic           underflow
);

    localparam logic [FAW:0] DEPTH_W = DEPTH[FAW:0];

    logic [SW-1:0]  mem [DEPTH];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic           push;
    logic           pop;

    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_W);
    assign prog_full = (count >= prog_thresh);
    assign dout      = empty ? '0 : mem[rd_ptr];

    // Pointer, occupancy and underflow bookkeeping; clear wins over traffic.
    always_ff @(posedge clk) begin
        if (!nreset || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates the output.
    always_ff @(posedge clk) begin
        if (nreset && !clear && push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spi_master_txq.sv
// SPI master transmit queue: emesh write decode and byte serializer.
// Splits 1/2/4/8-byte payloads into words for the shift engine FIFO.
module spi_master_txq
    import spi_master_txq_pkg::*;
#(
    parameter int AW    = 32,
    parameter int PW    = 104,
    parameter int SW    = 8,
    parameter int DEPTH = SPI_TXQ_DEPTH,
    parameter int FAW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           spi_en,
    input  logic           lsbfirst,
    input  logic           flush,
    input  logic [FAW:0]   prog_thresh,
    input  logic           access_in,
    input  logic [PW-1:0]  packet_in,
    output logic           wait_out,
    input  logic           fifo_read,
    output logic [SW-1:0]  fifo_dout,
    output logic           fifo_empty,
    output logic           fifo_full,
    output logic           fifo_prog_full,
    output logic [FAW:0]   fifo_count,
    output logic           underflow
);

    logic          write_in;
    logic [1:0]    datamode_in;
    logic [AW-1:0] dstaddr_in;
    logic [31:0]   data_in;
    logic [31:0]   srcaddr_in;
    logic          unused_pkt;

    assign write_in    = packet_in[0];
    assign datamode_in = packet_in[2:1];
    assign dstaddr_in  = packet_in[8 +: AW];
    assign data_in     = packet_in[8+AW +: 32];
    assign srcaddr_in  = packet_in[40+AW +: 32];
    assign unused_pkt  = ^packet_in;

    txq_state_t  state;
    logic [63:0] payload;
    logic [2:0]  byte_idx;
    logic [3:0]  bytes_left;
    logic        lsb_q;
    logic        load;
    logic        push;
    logic [SW-1:0] fifo_din;

    assign wait_out = (state == TXQ_SHIFT) | fifo_prog_full;

    assign load = spi_en & access_in & write_in
                & (dstaddr_in[5:0] == SPI_TX)
                & ~wait_out & ~flush;

    assign push = (state == TXQ_SHIFT) & ~fifo_full;

    // Current byte, zero-extended to the FIFO word width.
    always_comb begin
        fifo_din      = '0;
        fifo_din[7:0] = payload[{byte_idx, 3'b000} +: 8];
    end

    // Serializer: latch payload on load, emit one byte per unstalled cycle.
    always_ff @(posedge clk) begin
        if (!nreset || flush) begin
            state      <= TXQ_IDLE;
            payload    <= '0;
            byte_idx   <= '0;
            bytes_left <= '0;
            lsb_q      <= 1'b0;
        end else begin
            unique case (1'b1)
                load: begin
                    state      <= TXQ_SHIFT;
                    payload    <= {srcaddr_in, data_in};
                    bytes_left <= dm_nbytes(datamode_in);
                    lsb_q      <= lsbfirst;
                    byte_idx   <= lsbfirst ? 3'd0
                                : 3'(dm_nbytes(datamode_in) - 4'd1);
                end
                push: begin
                    bytes_left <= bytes_left - 4'd1;
                    byte_idx   <= lsb_q ? byte_idx + 3'd1
                                        : byte_idx - 3'd1;
                    if (bytes_left == 4'd1)
                        state <= TXQ_IDLE;
                end
                default: ;
            endcase
        end
    end

    spi_txq_mem #(
        .SW    (SW),
        .DEPTH (DEPTH),
        .FAW   (FAW)
    ) u_mem (
        .clk         (clk),
        .nreset      (nreset),
        .clear       (flush),
        .wr_en       (push),
        .din         (fifo_din),
        .rd_en       (fifo_read),
        .prog_thresh (prog_thresh),
        .dout        (fifo_dout),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .prog_full   (fifo_prog_full),
        .count       (fifo_count),
        .underflow   (underflow)
    );

endmodule
